// File: rtl/conbus_pkg.sv
// conbus_pkg: shared definitions for the conbus_rr Wishbone interconnect.
//   - Wishbone field widths and the packed width of one master-side bus
//   - clog2 helper for sizing counters and pointers
//   - error FSM state type
package conbus_pkg;

    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;
    localparam int CTI_W  = 3;
    localparam int SEL_W  = 4;
    localparam int MBUS_W = ADR_W + CTI_W + SEL_W + DAT_W + 3;

    // One master's view of the shared bus (MBUS_W bits)
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [CTI_W-1:0] cti;
        logic [SEL_W-1:0] sel;
        logic [DAT_W-1:0] dat;
        logic             we;
        logic             cyc;
        logic             stb;
    } mbus_t;

    typedef enum logic {
        OK  = 1'b0,
        ERR = 1'b1
    } err_state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conbus_rr_arb.sv
// conbus_rr_arb: registered round-robin arbiter.
//   sys_clk  : clock, rising edge
//   sys_rst  : synchronous active-high reset
//   req[NM]  : per-master request (master cyc)
//   gnt[NM]  : one-hot grant, or zero when the bus is idle
// A grant is held while the owner keeps req high. When the owner drops req
// (or nobody owns the bus) the next requester after the previous owner wins.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter int NM = 7
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [NM-1:0] req,
    output logic [NM-1:0] gnt
);

    localparam int LW = (NM > 1) ? clog2(NM) : 1;

    logic [NM-1:0] r_gnt;
    logic [LW-1:0] r_last;
    logic [NM-1:0] w_gnt_nxt;
    logic [LW-1:0] w_last_nxt;
    logic [LW-1:0] w_cand;
    logic          w_arb;
    logic          w_found;

    always_comb begin
        w_arb      = ~|(r_gnt & req);
        w_gnt_nxt  = r_gnt;
        w_last_nxt = r_last;
        w_found    = 1'b0;
        w_cand     = '0;
        if (w_arb) begin
            w_gnt_nxt = '0;
            // Scan last+1 .. last+NM; the previous owner is checked last
            for (int unsigned i = 1; i <= NM; i++) begin
                w_cand = LW'((32'(r_last) + i) % NM);
                if (!w_found && req[w_cand]) begin
                    w_found    = 1'b1;
                    w_gnt_nxt  = NM'(1) << w_cand;
                    w_last_nxt = w_cand;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_gnt  <= '0;
            r_last <= LW'(NM - 1);
        end else begin
            r_gnt  <= w_gnt_nxt;
            r_last <= w_last_nxt;
        end
    end

    assign gnt = r_gnt;

endmodule

// File: rtl/conbus_rr.sv
// conbus_rr: NM-master / NS-slave shared-bus Wishbone interconnect.
//   sys_clk, sys_rst      : clock and synchronous active-high reset
//   m_*_i                 : master request side, master k in lane k
//   m_dat_o               : selected slave read data, broadcast to all masters
//   m_ack_o / m_err_o     : termination, owner lane only
//   s_dat_o .. s_cyc_o    : owner request broadcast to every slave
//   s_stb_o               : strobe to the decoded slave only
//   s_dat_i / s_ack_i     : slave responses
// Unmapped addresses and slaves that do not ack within TIMEOUT cycles are
// terminated with a one-cycle bus error.
module conbus_rr
    import conbus_pkg::*;
#(
    parameter int                       NM       = 7,
    parameter int                       NS       = 7,
    parameter int                       S_ADDR_W = 4,
    parameter logic [NS*S_ADDR_W-1:0]   S_ADDR   = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                       TIMEOUT  = 1023
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [NM*32-1:0]   m_dat_i,
    input  logic [NM*32-1:0]   m_adr_i,
    input  logic [NM*3-1:0]    m_cti_i,
    input  logic [NM*4-1:0]    m_sel_i,
    input  logic [NM-1:0]      m_we_i,
    input  logic [NM-1:0]      m_cyc_i,
    input  logic [NM-1:0]      m_stb_i,
    output logic [NM*32-1:0]   m_dat_o,
    output logic [NM-1:0]      m_ack_o,
    output logic [NM-1:0]      m_err_o,
    output logic [NS*32-1:0]   s_dat_o,
    output logic [NS*32-1:0]   s_adr_o,
    output logic [NS*3-1:0]    s_cti_o,
    output logic [NS*4-1:0]    s_sel_o,
    output logic [NS-1:0]      s_we_o,
    output logic [NS-1:0]      s_cyc_o,
    output logic [NS-1:0]      s_stb_o,
    input  logic [NS*32-1:0]   s_dat_i,
    input  logic [NS-1:0]      s_ack_i
);

    localparam int              WD_W   = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic            WD_EN  = (TIMEOUT != 0);

    logic [NM-1:0]    w_gnt;
    mbus_t            w_bus;
    logic [NS-1:0]    w_sel;
    logic             w_hit;
    logic             w_mapped;
    logic             w_sack;
    logic [DAT_W-1:0] w_rdat;
    logic             w_err_pend;
    err_state_t       r_state;
    err_state_t       w_state_nxt;
    logic [WD_W-1:0]  r_wdog;

    conbus_rr_arb #(
        .NM (NM)
    ) u_arb (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .req     (m_cyc_i),
        .gnt     (w_gnt)
    );

    // Owner mux; grant is one-hot so the last hit is the only hit
    always_comb begin
        w_bus = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (w_gnt[k]) begin
                w_bus.adr = m_adr_i[k*ADR_W +: ADR_W];
                w_bus.cti = m_cti_i[k*CTI_W +: CTI_W];
                w_bus.sel = m_sel_i[k*SEL_W +: SEL_W];
                w_bus.dat = m_dat_i[k*DAT_W +: DAT_W];
                w_bus.we  = m_we_i[k];
                w_bus.cyc = m_cyc_i[k];
                w_bus.stb = m_stb_i[k];
            end
        end
    end

    // Prefix decode, lowest matching slot wins. Gated by ownership so an idle
    // bus (address 0) never selects a slave mapped at prefix 0.
    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (!w_hit && (|w_gnt) &&
                (w_bus.adr[ADR_W-1 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W])) begin
                w_sel[i] = 1'b1;
                w_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdat = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (w_sel[i]) begin
                w_rdat = s_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    assign w_mapped   = |w_sel;
    assign w_sack     = |(s_ack_i & w_sel);
    assign w_err_pend = (r_state == ERR);

    assign s_adr_o = {NS{w_bus.adr}};
    assign s_dat_o = {NS{w_bus.dat}};
    assign s_cti_o = {NS{w_bus.cti}};
    assign s_sel_o = {NS{w_bus.sel}};
    assign s_we_o  = {NS{w_bus.we}};
    assign s_cyc_o = {NS{w_bus.cyc}};
    assign s_stb_o = {NS{w_bus.cyc & w_bus.stb & ~w_err_pend}} & w_sel;

    assign m_dat_o = {NM{w_rdat}};
    assign m_ack_o = w_gnt & {NM{w_sack}};
    assign m_err_o = w_err_pend ? w_gnt : '0;

    // Error FSM: ERR is a single-cycle pulse
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= OK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OK: begin
                if ((w_bus.cyc & w_bus.stb & ~w_mapped) |
                    (WD_EN & (r_wdog == WD_MAX))) begin
                    w_state_nxt = ERR;
                end
            end
            ERR:     w_state_nxt = OK;
            default: w_state_nxt = OK;
        endcase
    end

    // Watchdog: counts strobed cycles to a mapped slave without an ack
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !WD_EN || w_err_pend || !w_bus.stb || w_sack) begin
            r_wdog <= '0;
        end else if (w_bus.cyc && w_bus.stb && w_mapped) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_conbus_rr.sv
// Testbench for conbus_rr (NM=3, NS=4, TIMEOUT=8).
module tb_conbus_rr;

    localparam int          NM  = 3;
    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [15:0] PFX = 16'h3210;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h3000_0010;
    localparam logic [31:0] A2 = 32'h2000_0200;
    localparam logic [31:0] AU = 32'hF000_0000;
    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_0001;
    localparam logic [31:0] D2 = 32'hC2C2_0002;
    localparam logic [31:0] D3 = 32'hDEAD_BEEF;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [NM*32-1:0]  m_dat_i, m_adr_i;
    logic [NM*3-1:0]   m_cti_i;
    logic [NM*4-1:0]   m_sel_i;
    logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
    logic [NM*32-1:0]  m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o;
    logic [NS*32-1:0]  s_dat_o, s_adr_o;
    logic [NS*3-1:0]   s_cti_o;
    logic [NS*4-1:0]   s_sel_o;
    logic [NS-1:0]     s_we_o, s_cyc_o, s_stb_o;
    logic [NS*32-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;

    conbus_rr #(
        .NM       (NM),
        .NS       (NS),
        .S_ADDR_W (4),
        .S_ADDR   (PFX),
        .TIMEOUT  (TO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .m_dat_i (m_dat_i),
        .m_adr_i (m_adr_i),
        .m_cti_i (m_cti_i),
        .m_sel_i (m_sel_i),
        .m_we_i  (m_we_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_dat_o (s_dat_o),
        .s_adr_o (s_adr_o),
        .s_cti_o (s_cti_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks;
    int n_errors;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int owner_of(input logic [31:0] adr);
        if (adr == A0) return 0;
        if (adr == A1) return 1;
        if (adr == A2) return 2;
        return 99;
    endfunction

    typedef struct {
        logic        rst;
        logic [2:0]  cyc;
        logic [2:0]  stb;
        logic [31:0] adr0;
        logic [3:0]  ack;
        logic [2:0]  e_ack;
        logic [2:0]  e_err;
        logic [3:0]  e_stb;
        logic [31:0] e_dat;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vt[19];

    // Reference model state: current owner (-1 = none), last owner,
    // error pulse pending, strobe-without-ack cycle count
    int mo, mlast, mwdog;
    bit merr;
    int slv_pfx[NS] = '{0, 1, 2, 3};

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        int          q[$];
        logic [2:0]  drop;
        int          first, errc;
        logic [2:0]  err_val, err_after;
        logic [3:0]  stb_in_err, stb_after;
        logic        ack_seen;

        n_checks = 0;
        n_errors = 0;

        vt[0]  = '{1'b1, 3'b000, 3'b000, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};
        vt[1]  = '{1'b0, 3'b101, 3'b101, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};
        vt[2]  = '{1'b0, 3'b101, 3'b101, A0, 4'b0000, 3'b000, 3'b000, 4'b0001, D0,    A0};
        vt[3]  = '{1'b0, 3'b101, 3'b101, A0, 4'b0001, 3'b001, 3'b000, 4'b0001, D0,    A0};
        vt[4]  = '{1'b0, 3'b100, 3'b100, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, D0,    A0};
        vt[5]  = '{1'b0, 3'b100, 3'b100, A0, 4'b0100, 3'b100, 3'b000, 4'b0100, D2,    A2};
        vt[6]  = '{1'b0, 3'b010, 3'b010, A0, 4'b1000, 3'b000, 3'b000, 4'b0000, D2,    A2};
        vt[7]  = '{1'b0, 3'b010, 3'b010, A0, 4'b1000, 3'b010, 3'b000, 4'b1000, D3,    A1};
        vt[8]  = '{1'b0, 3'b001, 3'b001, AU, 4'b0000, 3'b000, 3'b000, 4'b0000, D3,    A1};
        vt[9]  = '{1'b0, 3'b001, 3'b001, AU, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, AU};
        vt[10] = '{1'b0, 3'b001, 3'b001, AU, 4'b0000, 3'b000, 3'b001, 4'b0000, 32'h0, AU};
        vt[11] = '{1'b0, 3'b000, 3'b000, AU, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, AU};
        vt[12] = '{1'b0, 3'b000, 3'b000, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};
        vt[13] = '{1'b0, 3'b010, 3'b010, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};
        vt[14] = '{1'b1, 3'b011, 3'b011, A0, 4'b0000, 3'b000, 3'b000, 4'b1000, D3,    A1};
        vt[15] = '{1'b0, 3'b011, 3'b011, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};
        vt[16] = '{1'b0, 3'b011, 3'b011, A0, 4'b0000, 3'b000, 3'b000, 4'b0001, D0,    A0};
        vt[17] = '{1'b0, 3'b000, 3'b000, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, D0,    A0};
        vt[18] = '{1'b0, 3'b000, 3'b000, A0, 4'b0000, 3'b000, 3'b000, 4'b0000, 32'h0, 32'h0};

        sys_rst = 1'b1;
        m_dat_i = '0; m_adr_i = '0; m_cti_i = '0; m_sel_i = '0;
        m_we_i  = '0; m_cyc_i = '0; m_stb_i = '0;
        s_dat_i = {D3, D2, D1, D0};
        s_ack_i = '0;
        repeat (2) @(posedge sys_clk);
        #1;

        // ---------------- directed table ----------------
        for (int r = 0; r < 19; r++) begin
            sys_rst = vt[r].rst;
            m_cyc_i = vt[r].cyc;
            m_stb_i = vt[r].stb;
            m_adr_i = {A2, A1, vt[r].adr0};
            s_ack_i = vt[r].ack;
            s_dat_i = {D3, D2, D1, D0};
            @(negedge sys_clk);
            chk($sformatf("row%0d_ack", r), m_ack_o, vt[r].e_ack);
            chk($sformatf("row%0d_err", r), m_err_o, vt[r].e_err);
            chk($sformatf("row%0d_sstb", r), s_stb_o, vt[r].e_stb);
            chk($sformatf("row%0d_mdat", r), m_dat_o, {NM{vt[r].e_dat}});
            chk($sformatf("row%0d_sadr", r), s_adr_o, {NS{vt[r].e_adr}});
            @(posedge sys_clk);
            #1;
        end

        // ---------------- fairness: single-beat cycles ----------------
        m_cyc_i = '0; m_stb_i = '0; sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        m_adr_i = {A2, A1, A0};
        s_ack_i = '1;
        drop = '0;
        for (int n = 0; n < 40 && q.size() < 6; n++) begin
            m_cyc_i = ~drop;
            m_stb_i = ~drop;
            drop    = '0;
            @(negedge sys_clk);
            if (s_stb_o != '0) q.push_back(owner_of(s_adr_o[31:0]));
            drop = m_ack_o;
            @(posedge sys_clk);
            #1;
        end
        chk("fair_count", q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair_order%0d", i), (i < q.size()) ? q[i] : 99, i % 3);
        end

        // ---------------- watchdog timeout ----------------
        m_cyc_i = '0; m_stb_i = '0; sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        s_ack_i = '0;
        m_adr_i = {A2, A1, 32'h1000_0040};
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        first = -1; errc = -1;
        err_val = 3'h7; err_after = 3'h7;
        stb_in_err = 4'hF; stb_after = 4'hF;
        ack_seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge sys_clk);
            if (first < 0 && s_stb_o[1]) first = n;
            if (m_ack_o != '0) ack_seen = 1'b1;
            if (errc >= 0 && n == errc + 1) begin
                err_after = m_err_o;
                stb_after = s_stb_o;
            end
            if (errc < 0 && m_err_o != '0) begin
                errc       = n;
                err_val    = m_err_o;
                stb_in_err = s_stb_o;
            end
            @(posedge sys_clk);
            #1;
            if (errc >= 0 && n == errc + 1) break;
        end
        chk("to_latency", errc - first, TO + 1);
        chk("to_err", err_val, 3'b001);
        chk("to_stb_in_err", stb_in_err, 4'b0000);
        chk("to_err_after", err_after, 3'b000);
        chk("to_stb_after", stb_after, 4'b0010);
        chk("to_no_ack", ack_seen, 1'b0);
        m_cyc_i = '0; m_stb_i = '0;

        // ---------------- randomized vs reference model ----------------
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        mo = -1; mlast = NM - 1; merr = 1'b0; mwdog = 0;
        for (int n = 0; n < 3000; n++) begin
            logic              valid, b_we, b_cyc, b_stb;
            logic [31:0]       b_adr, b_dat, rword;
            logic [2:0]        b_cti;
            logic [3:0]        b_sel;
            logic [NS-1:0]     e_stb;
            logic [NM-1:0]     e_ack, e_err;
            int                idx, nxt, r;
            bit                new_err, acked;

            sys_rst = ($urandom_range(0, 199) == 0);
            for (int k = 0; k < NM; k++) begin
                if (m_cyc_i[k]) begin
                    if ($urandom_range(0, 7) == 0) m_cyc_i[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_cyc_i[k] = 1'b1;
                end
                m_stb_i[k] = m_cyc_i[k] & ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 5);
                m_adr_i[k*32 +: 32] = {(r == 5) ? 4'hF : 4'(r), 28'($urandom)};
                m_dat_i[k*32 +: 32] = $urandom;
                m_cti_i[k*3 +: 3]   = 3'($urandom);
                m_sel_i[k*4 +: 4]   = 4'($urandom);
                m_we_i[k]           = 1'($urandom);
            end
            for (int i = 0; i < NS; i++) begin
                s_ack_i[i]          = (((n / 256) % 2) == 0) && ($urandom_range(0, 3) == 0);
                s_dat_i[i*32 +: 32] = $urandom;
            end

            @(negedge sys_clk);
            valid = (mo >= 0);
            b_adr = valid ? m_adr_i[mo*32 +: 32] : 32'h0;
            b_dat = valid ? m_dat_i[mo*32 +: 32] : 32'h0;
            b_cti = valid ? m_cti_i[mo*3 +: 3]   : 3'h0;
            b_sel = valid ? m_sel_i[mo*4 +: 4]   : 4'h0;
            b_we  = valid ? m_we_i[mo]  : 1'b0;
            b_cyc = valid ? m_cyc_i[mo] : 1'b0;
            b_stb = valid ? m_stb_i[mo] : 1'b0;
            idx = -1;
            for (int i = 0; i < NS; i++) begin
                if (valid && idx < 0 && (b_adr >> 28) == slv_pfx[i]) idx = i;
            end
            e_stb = (b_cyc && b_stb && idx >= 0 && !merr) ? NS'(1) << idx : '0;
            acked = (idx >= 0) && s_ack_i[idx];
            e_ack = acked ? NM'(1) << mo : '0;
            e_err = (merr && valid) ? NM'(1) << mo : '0;
            rword = (idx >= 0) ? s_dat_i[idx*32 +: 32] : 32'h0;

            chk("rnd_ack", m_ack_o, e_ack);
            chk("rnd_err", m_err_o, e_err);
            chk("rnd_sstb", s_stb_o, e_stb);
            chk("rnd_mdat", m_dat_o, {NM{rword}});
            chk("rnd_sadr", s_adr_o, {NS{b_adr}});
            chk("rnd_sdat", s_dat_o, {NS{b_dat}});
            chk("rnd_sctl", {s_cti_o, s_sel_o, s_we_o, s_cyc_o},
                {{NS{b_cti}}, {NS{b_sel}}, {NS{b_we}}, {NS{b_cyc}}});

            if (sys_rst) begin
                mo = -1; mlast = NM - 1; merr = 1'b0; mwdog = 0;
            end else begin
                new_err = !merr && ((b_cyc && b_stb && idx < 0) || (TO != 0 && mwdog == TO));
                if (merr || !b_stb || acked) mwdog = 0;
                else if (b_cyc && b_stb && idx >= 0) mwdog = mwdog + 1;
                merr = new_err;
                if (!valid || !m_cyc_i[mo]) begin
                    nxt = -1;
                    for (int j = 1; j <= NM; j++) begin
                        if (nxt < 0 && m_cyc_i[(mlast + j) % NM]) nxt = (mlast + j) % NM;
                    end
                    mo = nxt;
                    if (nxt >= 0) mlast = nxt;
                end
            end
            @(posedge sys_clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
